execute: RTL
============

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs DX_A[31:0] and DX_B[31:0]: rs and rt operand values from decode.
REQ-004 SHALL have inputs DX_imm[31:0] (sign-extended immediate), DX_ALUSrc (1 = use DX_imm as B operand), DX_ALUctr[3:0] (operation) and DX_shamt[4:0] (shift amount).
REQ-005 SHALL have inputs DX_RD[4:0], DX_lwFlag, DX_swFlag and DX_valid: destination, load/store flags and instruction-valid.
REQ-006 SHALL have registered outputs ALUout[31:0], XM_RD[4:0], XM_lwFlag, XM_swFlag and XM_MD[31:0]; XM_MD carries the store data, equal to DX_B.
REQ-007 SHALL have output stall, 1 bit, combinational: upstream holds all DX_* inputs while it is high.

Function
REQ-008 SHALL encode DX_ALUctr as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLL, 8 SRL, 9 SRA, 10 LUI, 11 MFHI, 12 MFLO, 13 MULTU, 14 DIVU.
REQ-009 SHALL give code 15 a result of 0.
REQ-010 SHALL, for single-cycle ops, register the result and pass through RD and flags on the next clock edge, giving a latency of 1.
REQ-011 SHALL perform ADD/SUB as 32-bit wrap-around with no overflow trap.
REQ-012 SHALL make LUI produce {B[15:0],16'h0}.
REQ-013 SHALL take shift amounts from DX_shamt.
REQ-014 SHALL, when DX_valid=0, register a bubble: ALUout=0, XM_RD=0, both flags 0.
REQ-015 SHALL implement a multi-cycle unit with an FSM: IDLE -> BUSY on a valid MULTU/DIVU; BUSY runs 32 iterations -> DONE; DONE -> IDLE.
REQ-016 SHALL drive stall=1 in IDLE while a valid MULTU/DIVU is presented, and throughout BUSY; stall SHALL be 0 in DONE, so the op is consumed there.
REQ-017 SHALL hold stall high for 33 cycles per MULTU/DIVU.
REQ-018 SHALL register a bubble on every cycle in which stall=1, and in DONE; MULTU/DIVU write no GPR.
REQ-019 SHALL use a shift-add MULTU giving a 64-bit product {HI,LO}.
REQ-020 SHALL use a restoring DIVU giving LO=quotient, HI=remainder.
REQ-021 SHALL handle divide-by-zero as LO=32'hFFFFFFFF, HI=dividend.
REQ-022 SHALL update HI/LO only on the BUSY->DONE edge; an MFHI/MFLO issued the cycle after DONE SHALL see the new values.
REQ-023 SHALL let MFHI/MFLO return HI/LO with DX_RD as the destination.

Reset
REQ-024 SHALL, on rst=0, immediately clear all outputs, HI, LO and the iteration counter to 0 and set the FSM to IDLE.
REQ-025 SHALL, on reset asserted mid-BUSY, abort the operation with no HI/LO update; stall SHALL drop at once.

Configuration
REQ-026 SHALL compile the multi-cycle unit, HI/LO, FSM and the muldiv instance only when macro EXECUTE_MULDIV_EN is defined.
REQ-027 SHALL, without EXECUTE_MULDIV_EN, tie stall to 0 and treat codes 11-14 as bubbles (ALUout=0, XM_RD=0).

Structure
REQ-028 SHALL place the DX_ALUctr code constants, FSM state encoding and iteration count (32) in shared package mips_pkg.
REQ-029 SHALL contain one sub-module, muldiv: FSM, counter, HI/LO and start/done handshake; the ALU stays inline.

Verification
REQ-030 SHALL verify: ADD with A=7, B=0xFFFFFFFF, RD=3 -> next cycle ALUout=6, XM_RD=3.
REQ-031 SHALL verify: SLT with A=0xFFFFFFFF, B=1 -> ALUout=1; SRA with B=0x80000000, shamt=4 -> 0xF8000000.
REQ-032 SHALL verify: MULTU with A=0x10000, B=0x10000 -> stall high for 33 cycles; then MFHI=1, MFLO=0.
REQ-033 SHALL verify: DIVU with A=100, B=7 -> LO=14, HI=2; DIVU with B=0 -> LO=0xFFFFFFFF, HI=100.
REQ-034 SHALL verify: rst=0 at BUSY cycle 10 -> stall=0 and outputs 0 immediately, HI/LO=0; a following DX_valid=0 cycle -> bubble.
REQ-035 SHALL verify, built without EXECUTE_MULDIV_EN: MULTU -> stall never high, XM_RD=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU operation codes, the mul/div FSM state encoding
// and the iteration count of the multi-cycle unit.
package mips_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOR   = 4'd5,
      OP_SLT   = 4'd6,
      OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,
      OP_SRA   = 4'd9,
      OP_LUI   = 4'd10,
      OP_MFHI  = 4'd11,
      OP_MFLO  = 4'd12,
      OP_MULTU = 4'd13,
      OP_DIVU  = 4'd14,
      OP_NONE  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   localparam int MD_ITERS = 32;

   function automatic logic is_muldiv(alu_op_e op);
      return (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute operand bundle (DX_*) and the registered execute-to-memory results,
// plus the combinational stall back to decode.
interface execute_if;
   logic [31:0] DX_A;
   logic [31:0] DX_B;
   logic [31:0] DX_imm;
   logic        DX_ALUSrc;
   logic [3:0]  DX_ALUctr;
   logic [4:0]  DX_shamt;
   logic [4:0]  DX_RD;
   logic        DX_lwFlag;
   logic        DX_swFlag;
   logic        DX_valid;
   logic [31:0] ALUout;
   logic [4:0]  XM_RD;
   logic        XM_lwFlag;
   logic        XM_swFlag;
   logic [31:0] XM_MD;
   logic        stall;

   modport master (
      output DX_A, DX_B, DX_imm, DX_ALUSrc, DX_ALUctr, DX_shamt, DX_RD, DX_lwFlag, DX_swFlag,
             DX_valid,
      input  ALUout, XM_RD, XM_lwFlag, XM_swFlag, XM_MD, stall
   );

   modport slave (
      input  DX_A, DX_B, DX_imm, DX_ALUSrc, DX_ALUctr, DX_shamt, DX_RD, DX_lwFlag, DX_swFlag,
             DX_valid,
      output ALUout, XM_RD, XM_lwFlag, XM_swFlag, XM_MD, stall
   );
endinterface

// File: rtl/execute_muldiv.sv
// Multi-cycle MULTU/DIVU unit (shift-add multiply, restoring divide, 32 iterations);
// HI/LO change only on the BUSY->DONE edge. Instantiated only under EXECUTE_MULDIV_EN.
module muldiv
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        is_div_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   md_state_e   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] work_q, work_d;
   logic [31:0] opb_q, opb_d;
   logic        is_div_q, is_div_d;
   logic [31:0] hi_q, lo_q;
   logic [32:0] mul_sum, div_trial;
   logic        last_iter;

   assign last_iter = (cnt_q == 5'(MD_ITERS - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= MD_IDLE;
      else      state_q <= state_d;
   end

   // NOTE: each always_comb output is given a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start_i) state_d = MD_BUSY;
         MD_BUSY: if (last_iter) state_d = MD_DONE;
         MD_DONE: state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   // Reset gates the IDLE stall so a held MULTU/DIVU cannot freeze decode while in reset.
   always_comb begin
      stall_o = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         MD_IDLE: stall_o = rst & start_i;
         MD_BUSY: stall_o = 1'b1;
         MD_DONE: done_o  = 1'b1;
         default: ;
      endcase
   end

   // work holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
   always_comb begin
      mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opb_q} : 33'd0);
      div_trial = work_q[63:31] - {1'b0, opb_q};
      cnt_d     = cnt_q;
      work_d    = work_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      if (state_q == MD_IDLE && start_i) begin
         cnt_d    = '0;
         work_d   = {32'd0, a_i};
         opb_d    = b_i;
         is_div_d = is_div_i;
      end else if (state_q == MD_BUSY) begin
         cnt_d = cnt_q + 5'd1;
         if (is_div_q)
            work_d = div_trial[32] ? {work_q[62:0], 1'b0}
                                   : {div_trial[31:0], work_q[30:0], 1'b1};
         else
            work_d = {mul_sum, work_q[31:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         work_q   <= '0;
         opb_q    <= '0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
         if (state_q == MD_BUSY && last_iter) {hi_q, lo_q} <= work_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/execute.sv
// Execute stage: inline ALU feeding registered EX/MEM outputs. MULTU/DIVU, HI/LO and the
// stall handshake exist only when EXECUTE_MULDIV_EN is defined; otherwise codes 11-14 are bubbles.
module execute
   import mips_pkg::*;
(
   input logic      clk,
   input logic      rst,
   execute_if.slave ex
);

   alu_op_e     op;
   logic [31:0] opb, alu_res;
   logic        md_stall, bubble;
   logic [31:0] alu_q, alu_d, md_q, md_d;
   logic [4:0]  rd_q, rd_d;
   logic        lw_q, lw_d, sw_q, sw_d;

   assign op  = alu_op_e'(ex.DX_ALUctr);
   assign opb = ex.DX_ALUSrc ? ex.DX_imm : ex.DX_B;

`ifdef EXECUTE_MULDIV_EN
   logic        md_done;
   logic [31:0] hi, lo;

   muldiv u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start_i  (ex.DX_valid & is_muldiv(op)),
      .is_div_i (op == OP_DIVU),
      .a_i      (ex.DX_A),
      .b_i      (opb),
      .stall_o  (md_stall),
      .done_o   (md_done),
      .hi_o     (hi),
      .lo_o     (lo)
   );

   assign bubble = ~ex.DX_valid | is_muldiv(op) | md_stall | md_done;
`else
   assign md_stall = 1'b0;
   assign bubble   = ~ex.DX_valid | (op inside {OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU});
`endif

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = ex.DX_A + opb;
         OP_SUB:  alu_res = ex.DX_A - opb;
         OP_AND:  alu_res = ex.DX_A & opb;
         OP_OR:   alu_res = ex.DX_A | opb;
         OP_XOR:  alu_res = ex.DX_A ^ opb;
         OP_NOR:  alu_res = ~(ex.DX_A | opb);
         OP_SLT:  alu_res = {31'd0, $signed(ex.DX_A) < $signed(opb)};
         OP_SLL:  alu_res = opb << ex.DX_shamt;
         OP_SRL:  alu_res = opb >> ex.DX_shamt;
         OP_SRA:  alu_res = $unsigned($signed(opb) >>> ex.DX_shamt);
         OP_LUI:  alu_res = {opb[15:0], 16'h0};
`ifdef EXECUTE_MULDIV_EN
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
`endif
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      alu_d = '0;
      md_d  = '0;
      rd_d  = '0;
      lw_d  = 1'b0;
      sw_d  = 1'b0;
      if (!bubble) begin
         alu_d = alu_res;
         md_d  = ex.DX_B;
         rd_d  = ex.DX_RD;
         lw_d  = ex.DX_lwFlag;
         sw_d  = ex.DX_swFlag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_q <= '0;
         md_q  <= '0;
         rd_q  <= '0;
         lw_q  <= 1'b0;
         sw_q  <= 1'b0;
      end else begin
         alu_q <= alu_d;
         md_q  <= md_d;
         rd_q  <= rd_d;
         lw_q  <= lw_d;
         sw_q  <= sw_d;
      end
   end

   assign ex.ALUout    = alu_q;
   assign ex.XM_MD     = md_q;
   assign ex.XM_RD     = rd_q;
   assign ex.XM_lwFlag = lw_q;
   assign ex.XM_swFlag = sw_q;
   assign ex.stall     = md_stall;

endmodule
